// File: rtl/sram_req_ctrl.sv
// Request initiator for one port of a dual-port sram: single-beat writes, incrementing read bursts,
// read data returned in order through a small response FIFO with credit-based issue.
module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  rd_addr_reg, rd_addr_next;
    logic [LEN_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [ADDR_WIDTH-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]  mem_data_reg, mem_data_next;
    logic                   mem_we_reg, mem_we_next;

    // s1: address on the sram port this cycle; s2: mem_q carries that beat's data this cycle
    logic                   s1_valid_reg, s1_valid_next;
    logic                   s1_last_reg, s1_last_next;
    logic                   s2_valid_reg, s2_valid_next;
    logic                   s2_last_reg, s2_last_next;

    logic [DATA_WIDTH-1:0]  fifo_data [RSP_DEPTH];
    logic                   fifo_last [RSP_DEPTH];
    logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]          count_reg, count_next;
    logic [CW-1:0]          credit_used;
    logic                   credit_ok;
    logic                   push, pop;

    assign push        = s2_valid_reg;
    assign pop         = rsp_valid && rsp_ready;
    assign credit_used = count_reg + CW'(s1_valid_reg) + CW'(s2_valid_reg);
    assign credit_ok   = credit_used < CW'(RSP_DEPTH);
    assign count_next  = count_reg + CW'(push) - CW'(pop);

    assign req_ready = (state_reg == IDLE) && rst_n;
    assign rsp_valid = (count_reg != '0);
    assign rsp_rdata = fifo_data[rd_ptr_reg];
    assign rsp_last  = rsp_valid && fifo_last[rd_ptr_reg];
    assign busy      = (state_reg != IDLE) || s1_valid_reg || s2_valid_reg || (count_reg != '0);
    assign mem_addr  = mem_addr_reg;
    assign mem_data  = mem_data_reg;
    assign mem_we    = mem_we_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rd_addr_next  = rd_addr_reg;
        beat_cnt_next = beat_cnt_reg;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        mem_we_next   = 1'b0;
        s1_valid_next = 1'b0;
        s1_last_next  = 1'b0;
        s2_valid_next = s1_valid_reg;
        s2_last_next  = s1_last_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        state_next    = WRITE;
                        mem_we_next   = 1'b1;
                        mem_addr_next = req_addr;
                        mem_data_next = req_wdata;
                    end else begin
                        state_next    = READ;
                        rd_addr_next  = req_addr;
                        beat_cnt_next = req_len;
                    end
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            READ: begin
                // A beat only issues when a FIFO slot is guaranteed for its data
                if (credit_ok) begin
                    mem_addr_next = rd_addr_reg;
                    s1_valid_next = 1'b1;
                    s1_last_next  = (beat_cnt_reg == '0);
                    rd_addr_next  = rd_addr_reg + ADDR_WIDTH'(1);
                    if (beat_cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - LEN_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_reg  <= '0;
            beat_cnt_reg <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_we_reg   <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            rd_addr_reg  <= rd_addr_next;
            beat_cnt_reg <= beat_cnt_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            mem_we_reg   <= mem_we_next;
            s1_valid_reg <= s1_valid_next;
            s1_last_reg  <= s1_last_next;
            s2_valid_reg <= s2_valid_next;
            s2_last_reg  <= s2_last_next;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // Storage needs no reset: rsp_valid gates every read of it
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data[wr_ptr_reg] <= mem_q;
            fifo_last[wr_ptr_reg] <= s2_last_reg;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: sram behavioural model, in-order response scoreboard, scenario tasks.
module tb_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_last;
    logic        busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_q;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sram_mem [1024];
    logic [31:0] ref_mem  [1024];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rsp_count = 0;
    int          we_cycles = 0;
    logic        rand_mode = 1'b0;
    logic        rand_bit = 1'b0;
    logic        force_ready = 1'b1;

    assign rsp_ready = rand_mode ? rand_bit : force_ready;

    sram_req_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port sram model with one-cycle registered read
    always @(posedge clk) begin
        if (mem_we) sram_mem[mem_addr] <= mem_data;
        mem_q <= sram_mem[mem_addr];
    end

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) we_cycles++;
    end

    // Scoreboard: every popped response must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            exp_t e;
            checks++;
            rsp_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got data=%08h last=%0b, required no response", rsp_rdata, rsp_last);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.data || rsp_last !== e.last) begin
                    errors++;
                    $display("FAIL rsp_data: got data=%08h last=%0b, required data=%08h last=%0b",
                             rsp_rdata, rsp_last, e.data, e.last);
                end else begin
                    $display("rsp  cyc=%0d data=%08h last=%0b", cyc, rsp_rdata, rsp_last);
                end
            end
        end
    end

    // Drive one request until accepted; returns at accept edge + 1
    task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [3:0] len, output int acc_cyc);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            n++;
            if (n > 1000) begin
                errors++;
                checks++;
                $display("FAIL req_accept_timeout: got req_ready=%b, required 1 within 1000 cycles", req_ready);
                break;
            end
        end
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                exp_t e;
                logic [9:0] a;
                a = addr + 10'(i);
                e.data = ref_mem[a];
                e.last = (i == int'(len));
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
        $display("req  cyc=%0d we=%0b addr=%03h wdata=%08h len=%0d", acc_cyc, we, addr, wdata, len);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding busy=%b, required 0 and 0",
                     exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_len = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks += 5;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
        if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %03h, required 000", mem_addr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b, required 1", req_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int acc;
        int n;
        int base;
        force_ready = 1'b1;
        do_req(1'b1, 10'h010, 32'hDEADBEEF, 4'd0, acc);
        @(negedge clk);
        checks += 3;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL write_mem_we: got %b, required 1", mem_we); end
        if (mem_addr !== 10'h010) begin errors++; $display("FAIL write_mem_addr: got %03h, required 010", mem_addr); end
        if (mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL write_mem_data: got %08h, required deadbeef", mem_data); end
        base = rsp_count;
        do_req(1'b0, 10'h010, 32'h0, 4'd0, acc);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin errors++; $display("FAIL write_single_cycle: got mem_we=%b, required 0", mem_we); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - acc !== 3) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles, required 3", cyc - acc);
        end
        wait_drain();
        checks++;
        if (rsp_count - base !== 1) begin errors++; $display("FAIL read_count: got %0d, required 1", rsp_count - base); end
    endtask

    task automatic test_wrap();
        int acc;
        int base;
        logic [9:0] a;
        a = 10'h3FE;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, a, {22'h0, a}, 4'd0, acc);
            a = a + 10'd1;
        end
        base = rsp_count;
        do_req(1'b0, 10'h3FE, 32'h0, 4'd3, acc);
        wait_drain();
        checks++;
        if (rsp_count - base !== 4) begin errors++; $display("FAIL wrap_count: got %0d, required 4", rsp_count - base); end
    endtask

    task automatic test_backpressure();
        int acc;
        int base;
        int beats;
        logic [9:0] prev;
        force_ready = 1'b0;
        base = rsp_count;
        prev = mem_addr;
        beats = 0;
        do_req(1'b0, 10'h100, 32'h0, 4'd15, acc);
        repeat (20) begin
            @(negedge clk);
            if (mem_addr !== prev) beats++;
            prev = mem_addr;
        end
        checks += 3;
        if (beats !== 4) begin errors++; $display("FAIL stall_beats: got %0d beats issued, required 4", beats); end
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid: got %b, required 1", rsp_valid); end
        if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b, required 1", busy); end
        @(posedge clk);
        #1;
        force_ready = 1'b1;
        wait_drain();
        checks++;
        if (rsp_count - base !== 16) begin errors++; $display("FAIL stall_count: got %0d, required 16", rsp_count - base); end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int beats;
        int n;
        int bad_valid;
        int bad_addr;
        logic [9:0] prev;
        force_ready = 1'b1;
        prev = mem_addr;
        beats = 0;
        do_req(1'b0, 10'h200, 32'h0, 4'd15, acc);
        n = 0;
        while (beats < 5 && n < 100) begin
            @(negedge clk);
            if (mem_addr !== prev) beats++;
            prev = mem_addr;
            n++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checks += 4;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid: got %b, required 0", rsp_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_mem_we: got %b, required 0", mem_we); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got req_ready=%b, required 1", req_ready); end
        bad_valid = 0;
        bad_addr = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad_valid++;
            if (mem_addr !== 10'h000) bad_addr++;
        end
        checks += 2;
        if (bad_valid !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d cycles with rsp_valid, required 0", bad_valid); end
        if (bad_addr !== 0) begin errors++; $display("FAIL midrst_no_beats: got %0d cycles with beats, required 0", bad_addr); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int acc;
        int base_rsp;
        int base_we;
        int n_writes;
        int n_beats;
        logic we;
        logic [3:0] len;
        base_rsp = rsp_count;
        base_we = we_cycles;
        n_writes = 0;
        n_beats = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            we = ($urandom_range(0, 2) == 0);
            len = 4'($urandom_range(0, 15));
            if (we) n_writes++;
            else n_beats += int'(len) + 1;
            do_req(we, 10'($urandom_range(0, 1023)), $urandom, len, acc);
        end
        rand_mode = 1'b0;
        force_ready = 1'b1;
        wait_drain();
        checks += 2;
        if (rsp_count - base_rsp !== n_beats) begin
            errors++;
            $display("FAIL random_rsp_count: got %0d, required %0d", rsp_count - base_rsp, n_beats);
        end
        if (we_cycles - base_we !== n_writes) begin
            errors++;
            $display("FAIL random_we_cycles: got %0d, required %0d", we_cycles - base_we, n_writes);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 32'h5A5A0000 ^ (i * 32'h00010003);
            ref_mem[i]  = 32'h5A5A0000 ^ (i * 32'h00010003);
        end
        test_reset();
        test_write_read();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
